operand_loader: RTL

- Upstream feeder for the unrolled dot-product stage (the 5-element multiply/add chain with start/valid/busy handshake).
- Accepts operand pairs (a[i], b[i]) serially over a valid/ready handshake and buffers them into N parallel Q16.16 registers per array.
- Issues a one-cycle start to the downstream stage, waits for its valid, captures the result and reports it. Also runs a timeout watchdog.

---
 rtl/operand_loader_pkg.sv | 14 +
 rtl/operand_loader_if.sv | 19 +
 rtl/operand_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: Q16.16 constants and FSM encoding.
package operand_loader_pkg;

  // Q16.16 fixed-point helpers
  localparam int unsigned FRAC_BITS = 16;
  localparam logic [31:0] ONE       = 32'd65536;

  // Loader FSM encoding
  localparam int unsigned STATE_W  = 2;
  localparam logic [1:0]  ST_LOAD  = 2'd0;
  localparam logic [1:0]  ST_ISSUE = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;

endpackage

// File: rtl/operand_loader_if.sv
// Operand stream into the loader: one (a, b) pair per accepted transfer.
//   in_a, in_b : operand pair, Q16.16
//   in_valid   : producer has a pair
//   in_ready   : loader can take a pair this cycle
//   flush      : synchronous abort of a partial load
interface operand_loader_if #(
  parameter int unsigned W = 32
) ();

  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_valid;
  logic         in_ready;
  logic         flush;

  modport master (output in_a, in_b, in_valid, flush, input in_ready);
  modport slave  (input in_a, in_b, in_valid, flush, output in_ready);

endinterface

// File: rtl/operand_loader.sv
// Operand loader: buffers N serial operand pairs, fires a one-cycle start to
// the downstream dot-product stage, captures its result, and guards the wait
// with a timeout watchdog.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   in_if             : operand stream (slave side)
//   array_a/b_flat    : buffered operands, element i at [i*W +: W]
//   start_out         : one-cycle start pulse to downstream
//   down_valid/result : downstream result handshake
//   down_busy         : downstream status, not used for control
//   result, valid     : captured result and its one-cycle update pulse
//   busy              : high while issuing/waiting
//   error             : sticky timeout flag, cleared by the next accepted pair
//   count             : pairs loaded so far
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned N       = 5,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  operand_loader_if.slave          in_if,
  output logic [N*W-1:0]           array_a_flat,
  output logic [N*W-1:0]           array_b_flat,
  output logic                     start_out,
  input  logic                     down_valid,
  input  logic                     down_busy,
  input  logic [W-1:0]             down_result,
  output logic [W-1:0]             result,
  output logic                     valid,
  output logic                     busy,
  output logic                     error,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(N+1);

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   count_d;
  logic [CW-1:0]      wd, wd_d, wd_inc;
  logic [W-1:0]       result_d;
  logic               valid_d, error_d, busy_d, start_d;
  logic               in_ready_q, in_ready_d;
  logic               wr_en;

  // Downstream busy is informational only
  logic unused_down_busy;
  assign unused_down_busy = down_busy;

  assign in_if.in_ready = in_ready_q;
  assign wd_inc         = wd + CW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    count_d  = count;
    wd_d     = wd;
    result_d = result;
    error_d  = error;
    valid_d  = 1'b0;
    wr_en    = 1'b0;

    case (state)
      ST_LOAD: begin
        // flush has priority over a pending transfer
        if (in_if.flush) begin
          count_d = '0;
        end else if (in_if.in_valid && in_ready_q) begin
          wr_en   = 1'b1;
          error_d = 1'b0;
          count_d = count + CNT_W'(1);
          if (count == CNT_W'(N - 1)) begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wd_d = wd_inc;
        // wd==0 marks the first WAIT cycle, where a leftover valid is ignored;
        // a result arriving on the timeout cycle still wins
        if (down_valid && (wd != '0)) begin
          result_d = down_result;
          valid_d  = 1'b1;
          count_d  = '0;
          state_d  = ST_LOAD;
        end else if (wd_inc == CW'(TIMEOUT)) begin
          error_d = 1'b1;
          count_d = '0;
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    in_ready_d = (state_d == ST_LOAD);
    start_d    = (state_d == ST_ISSUE);
    busy_d     = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  // State, status and operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_LOAD;
      count        <= '0;
      wd           <= '0;
      result       <= '0;
      valid        <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
      start_out    <= 1'b0;
      in_ready_q   <= 1'b1;
      array_a_flat <= '0;
      array_b_flat <= '0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      wd         <= wd_d;
      result     <= result_d;
      valid      <= valid_d;
      error      <= error_d;
      busy       <= busy_d;
      start_out  <= start_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < int'(N); i++) begin
        if (wr_en && (count == CNT_W'(i))) begin
          array_a_flat[i*W +: W] <= in_if.in_a;
          array_b_flat[i*W +: W] <= in_if.in_b;
        end
      end
    end
  end

endmodule
